// File: rtl/traffic_light_monitor.sv
// Passive observer of the two-street lamp outputs: tracks colour phases, latches the first violation, counts cycles.
// Optional violation counter enabled by defining TLM_ERR_COUNT_EN.
module traffic_light_monitor #(
   parameter int YEL_CYC   = 2,
   parameter int MIN_GREEN = 4,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             Ga_i,
   input  logic             Ya_i,
   input  logic             Ra_i,
   input  logic             Gb_i,
   input  logic             Yb_i,
   input  logic             Rb_i,
   input  logic             clr_i,
   output logic             err_o,
   output logic [2:0]       err_code_o,
   output logic             err_street_o,
   output logic [CNT_W-1:0] cycles_a_o,
   output logic [CNT_W-1:0] cycles_b_o,
   output logic [7:0]       err_cnt_o,
   output logic [3:0]       dbg_state_o
);

   typedef enum logic [1:0] {UNK = 2'd0, GRN = 2'd1, YEL = 2'd2, RED = 2'd3} phase_t;

   localparam logic [2:0] C_NONE     = 3'd0;
   localparam logic [2:0] C_ONEHOT   = 3'd1;
   localparam logic [2:0] C_CONFLICT = 3'd2;
   localparam logic [2:0] C_SEQ      = 3'd3;
   localparam logic [2:0] C_YEL_LEN  = 3'd4;
   localparam logic [2:0] C_MIN_GRN  = 3'd5;

   phase_t     state_q   [2];
   phase_t     state_d   [2];
   phase_t     seen      [2];
   logic [7:0] dwell_q   [2];
   logic [7:0] dwell_d   [2];
   logic       partial_q [2];
   logic       partial_d [2];
   logic       yel_flag_q[2];
   logic       yel_flag_d[2];
   logic [2:0] code      [2];
   logic       cyc_inc   [2];
   logic [2:0] lamps     [2];

   logic       conflict;
   logic [1:0] nviol;
   logic       any_viol;
   logic [2:0] sel_code;
   logic       sel_street;

   assign lamps[0] = {Ga_i, Ya_i, Ra_i};
   assign lamps[1] = {Gb_i, Yb_i, Rb_i};
   assign conflict = (Ga_i | Ya_i) & (Gb_i | Yb_i);

   // partial marks a phase joined mid-way (from UNK), whose dwell undercounts,
   // so the too-short checks are waived for it; overlong yellow is still real.
   always_comb begin
      for (int s = 0; s < 2; s++) begin
         state_d[s]    = state_q[s];
         dwell_d[s]    = dwell_q[s];
         partial_d[s]  = partial_q[s];
         yel_flag_d[s] = yel_flag_q[s];
         code[s]       = C_NONE;
         cyc_inc[s]    = 1'b0;
         case (lamps[s])
            3'b100:  seen[s] = GRN;
            3'b010:  seen[s] = YEL;
            3'b001:  seen[s] = RED;
            default: seen[s] = UNK;
         endcase

         if (seen[s] == UNK) begin
            code[s]       = C_ONEHOT;
            state_d[s]    = UNK;
            dwell_d[s]    = 8'd0;
            partial_d[s]  = 1'b0;
            yel_flag_d[s] = 1'b0;
         end else if (state_q[s] == UNK) begin
            state_d[s]    = seen[s];
            dwell_d[s]    = 8'd1;
            partial_d[s]  = 1'b1;
            yel_flag_d[s] = 1'b0;
         end else if (seen[s] == state_q[s]) begin
            dwell_d[s] = (dwell_q[s] == 8'hFF) ? 8'hFF : dwell_q[s] + 8'd1;
            if (state_q[s] == YEL && int'(dwell_q[s]) == YEL_CYC && !yel_flag_q[s]) begin
               code[s]       = C_YEL_LEN;
               yel_flag_d[s] = 1'b1;
            end
         end else begin
            state_d[s]    = seen[s];
            dwell_d[s]    = 8'd1;
            partial_d[s]  = 1'b0;
            yel_flag_d[s] = 1'b0;
            case (state_q[s])
               GRN: begin
                  if (seen[s] != YEL)
                     code[s] = C_SEQ;
                  else if (!partial_q[s] && int'(dwell_q[s]) < MIN_GREEN)
                     code[s] = C_MIN_GRN;
               end
               YEL: begin
                  if (seen[s] != RED)
                     code[s] = C_SEQ;
                  else begin
                     cyc_inc[s] = 1'b1;
                     if (!partial_q[s] && !yel_flag_q[s] && int'(dwell_q[s]) != YEL_CYC)
                        code[s] = C_YEL_LEN;
                  end
               end
               RED: begin
                  if (seen[s] != GRN)
                     code[s] = C_SEQ;
               end
               default: ;
            endcase
         end
      end
   end

   // Walk codes high to low so the last hit is the lowest code, street A last within a code.
   always_comb begin
      sel_code   = C_NONE;
      sel_street = 1'b0;
      for (int c = 5; c >= 1; c--) begin
         if (code[1] == 3'(c)) begin
            sel_code   = 3'(c);
            sel_street = 1'b1;
         end
         if (c == 2 && conflict) begin
            sel_code   = C_CONFLICT;
            sel_street = 1'b0;
         end
         if (code[0] == 3'(c)) begin
            sel_code   = 3'(c);
            sel_street = 1'b0;
         end
      end
   end

   assign nviol    = {1'b0, code[0] != C_NONE} + {1'b0, code[1] != C_NONE} + {1'b0, conflict};
   assign any_viol = (nviol != 2'd0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s < 2; s++) begin
            state_q[s]    <= UNK;
            dwell_q[s]    <= 8'd0;
            partial_q[s]  <= 1'b0;
            yel_flag_q[s] <= 1'b0;
         end
      end else begin
         for (int s = 0; s < 2; s++) begin
            state_q[s]    <= state_d[s];
            dwell_q[s]    <= dwell_d[s];
            partial_q[s]  <= partial_d[s];
            yel_flag_q[s] <= yel_flag_d[s];
         end
      end
   end

   // A violation in the clearing sample is recorded: set wins over clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_o        <= 1'b0;
         err_code_o   <= C_NONE;
         err_street_o <= 1'b0;
      end else if (clr_i) begin
         err_o        <= any_viol;
         err_code_o   <= sel_code;
         err_street_o <= sel_street;
      end else if (any_viol && !err_o) begin
         err_o        <= 1'b1;
         err_code_o   <= sel_code;
         err_street_o <= sel_street;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cycles_a_o <= '0;
         cycles_b_o <= '0;
      end else begin
         cycles_a_o <= cycles_a_o + CNT_W'(cyc_inc[0]);
         cycles_b_o <= cycles_b_o + CNT_W'(cyc_inc[1]);
      end
   end

`ifdef TLM_ERR_COUNT_EN
   logic [8:0] cnt_sum;

   assign cnt_sum = (clr_i ? 9'd0 : {1'b0, err_cnt_o}) + {7'd0, nviol};

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         err_cnt_o <= 8'd0;
      else
         err_cnt_o <= cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
   end
`else
   assign err_cnt_o = 8'd0;
`endif

   assign dbg_state_o = {state_q[1], state_q[0]};

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed-vector bench for traffic_light_monitor; expected values are hand-computed per vector.
// Error-count expectations follow TLM_ERR_COUNT_EN when the bench is built with it.
module tb_traffic_light_monitor;

   localparam logic [2:0] G   = 3'b100;
   localparam logic [2:0] Y   = 3'b010;
   localparam logic [2:0] R   = 3'b001;
   localparam logic [2:0] OFF = 3'b000;
   localparam logic [2:0] GR  = 3'b101;

`ifdef TLM_ERR_COUNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        Ga_i = 1'b0, Ya_i = 1'b0, Ra_i = 1'b0;
   logic        Gb_i = 1'b0, Yb_i = 1'b0, Rb_i = 1'b0;
   logic        clr_i = 1'b0;
   logic        err_o;
   logic [2:0]  err_code_o;
   logic        err_street_o;
   logic [15:0] cycles_a_o;
   logic [15:0] cycles_b_o;
   logic [7:0]  err_cnt_o;
   logic [3:0]  dbg_state_o;

   int n_vec = 0;
   int n_bad = 0;

   traffic_light_monitor dut (
      .clk          (clk),
      .rst          (rst),
      .Ga_i         (Ga_i),
      .Ya_i         (Ya_i),
      .Ra_i         (Ra_i),
      .Gb_i         (Gb_i),
      .Yb_i         (Yb_i),
      .Rb_i         (Rb_i),
      .clr_i        (clr_i),
      .err_o        (err_o),
      .err_code_o   (err_code_o),
      .err_street_o (err_street_o),
      .cycles_a_o   (cycles_a_o),
      .cycles_b_o   (cycles_b_o),
      .err_cnt_o    (err_cnt_o),
      .dbg_state_o  (dbg_state_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Called at a falling edge: applies one sample, returns at the next falling edge.
   task automatic drive(input logic [2:0] a, input logic [2:0] b, input logic clr = 1'b0);
      {Ga_i, Ya_i, Ra_i} = a;
      {Gb_i, Yb_i, Rb_i} = b;
      clr_i = clr;
      @(negedge clk);
      clr_i = 1'b0;
   endtask

   task automatic check_status(input string tag, input logic e, input logic [2:0] c,
                               input logic st, input logic [7:0] cnt);
      check({tag, ".err"}, 32'(err_o), 32'(e));
      check({tag, ".code"}, 32'(err_code_o), 32'(c));
      check({tag, ".street"}, 32'(err_street_o), 32'(st));
      check({tag, ".cnt"}, 32'(err_cnt_o), CNT_EN ? 32'(cnt) : 32'd0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check_status("reset", 1'b0, 3'd0, 1'b0, 8'd0);
      check("reset.cyc_a", 32'(cycles_a_o), 32'd0);
      check("reset.cyc_b", 32'(cycles_b_o), 32'd0);
      check("reset.state", 32'(dbg_state_o), 32'h0);
      rst = 1'b0;

      repeat (10) drive(R, R);
      check_status("allred", 1'b0, 3'd0, 1'b0, 8'd0);
      check("allred.cyc_a", 32'(cycles_a_o), 32'd0);
      check("allred.cyc_b", 32'(cycles_b_o), 32'd0);
      check("allred.state", 32'(dbg_state_o), 32'hF);

      for (int k = 0; k < 3; k++) begin
         repeat (4) drive(G, R);
         repeat (2) drive(Y, R);
         drive(R, R);
      end
      check_status("cycles3", 1'b0, 3'd0, 1'b0, 8'd0);
      check("cycles3.cyc_a", 32'(cycles_a_o), 32'd3);
      check("cycles3.cyc_b", 32'(cycles_b_o), 32'd0);

      drive(G, G);
      check_status("conflict", 1'b1, 3'd2, 1'b0, 8'd1);

      drive(R, R);
      check_status("seq_held", 1'b1, 3'd2, 1'b0, 8'd3);
      drive(R, R, 1'b1);
      check_status("clr", 1'b0, 3'd0, 1'b0, 8'd0);
      check("clr.cyc_a", 32'(cycles_a_o), 32'd3);

      repeat (5) drive(G, R);
      drive(Y, R);
      drive(R, R);
      check_status("yel_short", 1'b1, 3'd4, 1'b0, 8'd1);
      check("yel_short.cyc_a", 32'(cycles_a_o), 32'd4);
      repeat (2) drive(G, R);
      repeat (2) drive(Y, R);
      check_status("min_grn", 1'b1, 3'd4, 1'b0, 8'd2);

      drive(R, R);
      check("yel_ok.cyc_a", 32'(cycles_a_o), 32'd5);
      drive(R, R, 1'b1);
      drive(R, G);
      check_status("b_green", 1'b0, 3'd0, 1'b0, 8'd0);
      drive(GR, R);
      check_status("multi", 1'b1, 3'd1, 1'b0, 8'd2);
      check("multi.state", 32'(dbg_state_o), 32'hC);

      drive(R, R, 1'b1);
      check_status("clr2", 1'b0, 3'd0, 1'b0, 8'd0);
      drive(OFF, R, 1'b1);
      check_status("set_over_clr", 1'b1, 3'd1, 1'b0, 8'd1);
      drive(R, R);
      drive(R, R, 1'b1);
      check_status("clr3", 1'b0, 3'd0, 1'b0, 8'd0);

      repeat (4) drive(R, G);
      repeat (2) drive(R, Y);
      check_status("b_yel2", 1'b0, 3'd0, 1'b0, 8'd0);
      drive(R, Y);
      check_status("b_yel_long", 1'b1, 3'd4, 1'b1, 8'd1);
      drive(R, R);
      check_status("b_yel_once", 1'b1, 3'd4, 1'b1, 8'd1);
      check("b_yel_once.cyc_b", 32'(cycles_b_o), 32'd1);
      drive(R, R, 1'b1);

      repeat (4) drive(G, R);
      drive(Y, R);
      check("pre_rst.cyc_a", 32'(cycles_a_o), 32'd5);
      rst = 1'b1;
      #1;
      check_status("mid_rst", 1'b0, 3'd0, 1'b0, 8'd0);
      check("mid_rst.cyc_a", 32'(cycles_a_o), 32'd0);
      check("mid_rst.cyc_b", 32'(cycles_b_o), 32'd0);
      check("mid_rst.state", 32'(dbg_state_o), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      drive(Y, R);
      drive(R, R);
      check_status("resume", 1'b0, 3'd0, 1'b0, 8'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/traffic_light_monitor.md
# traffic_light_monitor

Passive checker on the light-output side of the two-street traffic light controller. It samples the six lamp signals (Ga/Ya/Ra, Gb/Yb/Rb) every clock and tracks each street's colour phase. It flags the first safety or sequencing violation in a sticky status register and counts completed green-yellow-red cycles per street. It sits beside the controller in the top-level and in benches as a bus-style observer; it never drives the lamps.

## Interface
- `YEL_CYC`, default 2: required yellow dwell, in clock cycles.
- `MIN_GREEN`, default 4: minimum green dwell, in cycles, before yellow is allowed.
- `CNT_W`, default 16: width of the per-street cycle counters.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous reset, active-high.
- `Ga_i`, `Ya_i`, `Ra_i` in 1 each: street A lamps.
- `Gb_i`, `Yb_i`, `Rb_i` in 1 each: street B lamps.
- `clr_i` in 1: synchronous clear of the error status and error count. Trackers and cycle counters are unaffected.
- `err_o` out 1: sticky flag; at least one violation has occurred.
- `err_code_o` out 3: code of the first violation; 0 means none.
- `err_street_o` out 1: street of the first violation; 0 = A, 1 = B.
- `cycles_a_o`, `cycles_b_o` out CNT_W: completed cycles per street.
- `err_cnt_o` out 8: total violations counted (see Configuration).

## Operation
- Per-street tracker FSM with states UNK, GRN, YEL, RED, plus an 8-bit dwell counter.
  - Dwell is the number of consecutive samples in the current colour. It is 1 on entry and saturates at 255.
- UNK is entered on reset and after any one-hot violation on that street.
  - From UNK, the first valid one-hot sample sets the state and sets dwell to 1.
  - No sequence or duration check is applied on that transition.
- Legal transitions: G→G, G→Y, Y→Y, Y→R, R→R, R→G.
- Violation codes:
  - 1 ONEHOT: a street's lamp vector is not exactly one-hot (includes all-off).
  - 2 CONFLICT: (Ga|Ya) and (Gb|Yb) are both high in the same sample. Reported as street A.
  - 3 SEQ: illegal transition, i.e. G→R, Y→G or R→Y.
  - 4 YEL_LEN: Y→R with yellow dwell ≠ YEL_CYC, or yellow dwell would reach YEL_CYC+1 while still yellow. Flagged once per yellow phase.
  - 5 MIN_GRN: G→Y with green dwell < MIN_GREEN.
- Several violations in the same sample:
  - The lowest code wins.
  - For equal codes, street A wins.
  - Each violation still increments the error count.
- Once `err_o` is set, `err_code_o` and `err_street_o` hold until `rst` or `clr_i`.
- Cycle counters increment on each legal Y→R transition. They wrap modulo 2^CNT_W.
- A transition that raises code 4 still increments the cycle counter. A code 3 transition does not.

## Timing
- Reset values: all outputs 0; both trackers UNK; dwell 0.
- Lamp inputs are compared combinationally against the registered tracker state.
- Latency: a violation in the sample taken at edge k is visible on `err_o` and `err_code_o` after edge k, i.e. 1 cycle.
- Counter updates follow the same timing.
- `clr_i` high at edge k: status reads 0 after edge k.
  - If a violation is sampled at the same edge k, it is recorded, so set wins over clear.
- `rst` asserted mid-phase clears everything immediately. Checking resumes from UNK, so resuming mid-yellow raises no false code 4.

## Configuration
- Macro: `TLM_ERR_COUNT_EN`.
- When defined:
  - `err_cnt_o` counts every violation detected, including several in the same sample.
  - It saturates at 255.
  - It is cleared by `rst` or `clr_i`.
- When undefined: `err_cnt_o` is tied to 0 and no counter logic is built.

## Test plan
- Reset, then Ra=Rb=1 for 10 cycles → `err_o`=0, `cycles_a_o`=0, `cycles_b_o`=0.
- A runs G×4, Y×2, R while B is held red, repeated 3 times → `cycles_a_o`=3, `err_o`=0.
- Ga=1 and Gb=1 for one cycle → after that edge `err_o`=1, `err_code_o`=2, `err_street_o`=0.
- A runs G×5, Y×1, R → code 4 at the R sample. A later G×2, Y×2 gives no change in code, which stays 4. With the macro, `err_cnt_o`=2.
- In the same sample, A has Ga=Ra=1 and B goes Gb→Rb → `err_code_o`=1, `err_street_o`=0. With the macro, `err_cnt_o`=2.
- Pulse `clr_i`, then assert `rst` mid-yellow and resume with Y×1, R → `err_o`=0. `cycles_*` are preserved across `clr_i` and are 0 after `rst`.
